// File: rtl/step_ctrl.sv
// Single-step / free-run controller: turns a raw push-button and run switch into
// clean one-cycle step pulses for the PC write enable, with debounce and auto-repeat.
module step_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 50_000_000,
    parameter int REPEAT_CYCLES   = 10_000_000,
    parameter int RUN_DIV         = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn,
    input  logic        run_en,
    input  logic        halt,
    output logic        step,
    output logic [31:0] step_cnt,
    output logic [1:0]  mode
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);
    localparam int REP_W  = $clog2(REPEAT_CYCLES + 1);
    localparam int RUN_W  = $clog2(RUN_DIV + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        REPEAT  = 2'd2,
        RUN     = 2'd3
    } state_t;

    state_t            state;
    logic              btn_m, btn_s, run_m, run_s;
    logic              btn_db;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic [RUN_W-1:0]  run_cnt;
    logic              hold_done, rep_done, run_done;
    logic              step_req;

    // NOTE: every flop uses non-blocking assignment so all registers update
    // from pre-edge values; blocking here would collapse the 2-flop synchroniser.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
            run_m <= 1'b0;
            run_s <= 1'b0;
        end else begin
            btn_m <= btn;
            btn_s <= btn_m;
            run_m <= run_en;
            run_s <= run_m;
        end
    end

    // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_db <= 1'b0;
            db_cnt <= '0;
        end else if (btn_s == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            btn_db <= btn_s;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    assign hold_done = (hold_cnt == HOLD_W'(HOLD_CYCLES - 1));
    assign rep_done  = (rep_cnt == REP_W'(REPEAT_CYCLES - 1));
    assign run_done  = (run_cnt == RUN_W'(RUN_DIV - 1));

    // NOTE: the default assignment first keeps this block purely combinational;
    // a path that leaves step_req unassigned would infer a latch.
    always_comb begin
        step_req = 1'b0;
        if (run_s) begin
            step_req = (state == RUN) && run_done;
        end else begin
            case (state)
                IDLE:    step_req = btn_db;
                PRESSED: step_req = btn_db && hold_done;
                REPEAT:  step_req = btn_db && rep_done;
                default: step_req = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            rep_cnt  <= '0;
            run_cnt  <= '0;
            step     <= 1'b0;
        end else begin
            // A halted request is simply dropped; counters advance regardless.
            step <= step_req && !halt;
            if (run_s) begin
                if (state != RUN) begin
                    state   <= RUN;
                    run_cnt <= '0;
                end else if (run_done) begin
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + RUN_W'(1);
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (btn_db) begin
                            state    <= PRESSED;
                            hold_cnt <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!btn_db) begin
                            state <= IDLE;
                        end else if (hold_done) begin
                            state   <= REPEAT;
                            rep_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                    REPEAT: begin
                        if (!btn_db) begin
                            state <= IDLE;
                        end else if (rep_done) begin
                            rep_cnt <= '0;
                        end else begin
                            rep_cnt <= rep_cnt + REP_W'(1);
                        end
                    end
                    default: begin
                        // Leaving RUN with the button still held resumes hold timing from zero.
                        run_cnt  <= '0;
                        hold_cnt <= '0;
                        state    <= btn_db ? PRESSED : IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (step) begin
            step_cnt <= step_cnt + 32'd1;
        end
    end

    assign mode = state;

endmodule

// File: doc/step_ctrl.md
# step_ctrl

Single-step/run controller sitting directly upstream of the PC register write enable in the stepping RV32 board top. It turns the raw push-button into a clean, one-cycle `step` pulse: synchronised, debounced, with auto-repeat on long press. It also supports a free-run mode from a switch level and a halt input that blocks all steps. It replaces the bare edge detector as the source of `pc_wen` and the RAM write qualifier, and reports a step count and mode for the seven-segment display.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive cycles a synchronised input must disagree with the debounced level before the level flips (≥1).
- `HOLD_CYCLES`, 50_000_000: cycles after the initial press step before auto-repeat starts (≥1).
- `REPEAT_CYCLES`, 10_000_000: auto-repeat step period (≥1).
- `RUN_DIV`, 25_000_000: free-run step period (≥1).

Ports:
- `clk`, in, 1: single clock domain.
- `rst`, in, 1: asynchronous, active-high reset.
- `btn`, in, 1: raw push-button, asynchronous, active-high.
- `run_en`, in, 1: raw free-run switch, asynchronous level.
- `halt`, in, 1: synchronous; 1 suppresses every step.
- `step`, out, 1: registered one-cycle step pulse; drives `pc_wen`.
- `step_cnt`, out, 32: number of steps issued, wraps.
- `mode`, out, 2: 0 IDLE, 1 PRESSED, 2 REPEAT, 3 RUN.

## Operation

- Reset: `step`=0, `step_cnt`=0, `mode`=0. The synchroniser flops, debounced level, and all counters are 0. The FSM is in IDLE. Async assertion clears everything immediately, including mid-debounce and mid-repeat.
- Synchronisers: `btn` and `run_en` each pass through 2 flops, giving `btn_s` and `run_s`. `run_s` is not debounced.
- Debounce:
  - `db_cnt` increments each cycle `btn_s` != `btn_db` and clears on any agreement.
  - On the cycle `db_cnt` would reach `DEBOUNCE_CYCLES`, `btn_db` takes `btn_s` and `db_cnt` clears.
  - Glitches shorter than `DEBOUNCE_CYCLES` never change `btn_db`.
- FSM (registered state = `mode`):
  - Any state with `run_s`=1 → RUN. A step request occurs every `RUN_DIV` cycles; `run_cnt` starts at 0 on entry to RUN. The button is ignored apart from debounce tracking.
  - RUN with `run_s`=0 → PRESSED if `btn_db`=1, else IDLE. `run_cnt` clears. No step is issued on exit.
  - IDLE, `btn_db` rises → PRESSED, issue one step request, clear `hold_cnt`.
  - PRESSED: `hold_cnt` increments. When `hold_cnt` reaches `HOLD_CYCLES`: issue a step request, go to REPEAT, clear `rep_cnt`. If `btn_db`=0 → IDLE.
  - REPEAT: `rep_cnt` increments and issues a step request each time it reaches `REPEAT_CYCLES`, then clears. If `btn_db`=0 → IDLE.
  - Release has priority over a same-cycle hold or repeat expiry: no step is issued.
- Step output:
  - `step` is the registered version of (step request AND NOT `halt`).
  - A halted request is dropped, not queued. Internal counters keep running under halt.
- `step_cnt` increments by 1 on each cycle `step`=1, modulo 2^32 (0xFFFF_FFFF → 0).

## Timing

- Button press latency: `btn` is first sampled 1 at edge E. `btn_s`=1 after E+1. `btn_db`=1 after E+1+`DEBOUNCE_CYCLES`. `step`=1 after E+2+`DEBOUNCE_CYCLES`, for exactly 1 cycle.
- `step_cnt` updates on the edge after `step` is high. It lags `step` by one cycle.
- Auto-repeat:
  - The second step comes exactly `HOLD_CYCLES` cycles after the first.
  - Each later step comes `REPEAT_CYCLES` cycles after the previous one.
- Free run:
  - The first step comes `RUN_DIV` cycles after `mode` becomes 3.
  - Then one step every `RUN_DIV` cycles.
- `halt` is sampled in the request cycle. The `step` pulse for that request is suppressed on the next edge.
- `step` never stays high for 2 consecutive cycles unless a period parameter is 1.

## Test plan

Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `HOLD_CYCLES`=20, `REPEAT_CYCLES`=5, `RUN_DIV`=3.

- Reset, then `btn` 0 for 50 cycles → `step`=0, `step_cnt`=0, `mode`=0 throughout.
- `btn` pulses of 3 cycles, repeated 5 times with 3-cycle gaps → no `step`, `step_cnt`=0.
- `btn` held 10 cycles from edge E → single `step` after E+6, `step_cnt`=1. On release, `mode` returns to 0 after 4 debounce cycles.
- `btn` held 40 cycles → steps at first-step cycle T, T+20, T+25, T+30, T+35 (while still held), `mode`=2 after T+20.
- `run_en`=1 for 12 cycles after sync, with `halt`=1 on the second request → steps at sync+3, sync+9, sync+12 (the second is dropped), `step_cnt`=3.
- Preload `step_cnt`=0xFFFF_FFFF via forced steps, one more step → 0x0000_0000. Assert `rst` mid-REPEAT → all outputs are 0 immediately.
